axil_led_ctrl: RTL and testbench
================================

# axil_led_ctrl

AXI4-Lite register slave that drives the board LED bank with static or blinking patterns. It attaches to one master port of the 1x5 AXI-Lite interconnect (one of m00..m04) and is the terminal consumer of that port's transactions. All register accesses complete with single-beat responses. The LED outputs are registered.

## Interface
- DATA_WIDTH, 32: AXI-Lite data width; only 32 is supported.
- ADDR_WIDTH, 16: AXI-Lite address width; must match the interconnect.
- STRB_WIDTH, DATA_WIDTH/8: write strobe width.
- LED_COUNT, 8: number of LED outputs, 1..24.
- ID_VALUE, 32'h4C45_4401: constant returned by the ID register.

Ports:
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  asynchronous, active-low reset.
- s_axil_awaddr  in  ADDR_WIDTH  write address.
- s_axil_awprot  in  3  ignored.
- s_axil_awvalid / s_axil_awready  in / out  1  AW handshake.
- s_axil_wdata  in  DATA_WIDTH  write data.
- s_axil_wstrb  in  STRB_WIDTH  byte enables.
- s_axil_wvalid / s_axil_wready  in / out  1  W handshake.
- s_axil_bresp  out  2  write response.
- s_axil_bvalid / s_axil_bready  out / in  1  B handshake.
- s_axil_araddr  in  ADDR_WIDTH  read address.
- s_axil_arprot  in  3  ignored.
- s_axil_arvalid / s_axil_arready  in / out  1  AR handshake.
- s_axil_rdata  out  DATA_WIDTH  read data.
- s_axil_rresp  out  2  read response.
- s_axil_rvalid / s_axil_rready  out / in  1  R handshake.
- led_out  out  LED_COUNT  registered LED drive, active-high.

## Operation
Address decoding:
- Only addr[7:2] is decoded. addr[1:0] and addr[ADDR_WIDTH-1:8] are ignored, so the register map aliases every 256 bytes.

Register map:
- 0x00 CTRL (RW, reset 0).
  - [0] enable.
  - [1] blink.
  - Other bits read 0.
- 0x04 VALUE (RW, reset 0): [LED_COUNT-1:0] LED pattern.
- 0x08 PERIOD (RW, reset 0): half-period of the blink, in clk cycles.
- 0x0C STATUS (RO).
  - [0] phase.
  - [LED_COUNT+7:8] current led_out.
- 0x10 ID (RO): ID_VALUE.
- Offsets 0x14–0xFF: unmapped.
  - Reads return rdata=0 with rresp=SLVERR (2'b10).
  - Writes have no effect and return bresp=SLVERR.
- Writes to the RO registers (STATUS, ID) are ignored and return OKAY.
- Mapped accesses return OKAY (2'b00).

Write strobes:
- Byte lane i is updated only when wstrb[i]=1.
- Bits outside each register's implemented width are discarded.

Write path:
- AW and W are accepted independently, in any order, and each is latched into its own holding register.
- awready = !aw_held && !bvalid.
- wready = !w_held && !bvalid.
- Once both are held (including the case where both handshake in the same cycle N), the write commits on the following edge: the register updates and bvalid rises at N+1.
- The holding registers clear at commit.
- bvalid holds until bready is sampled high.

Read path:
- arready = !rvalid.
- A handshake in cycle N produces rvalid=1 at N+1, with rdata sampled from register state at N.
- rvalid and rdata stay stable until rready is sampled high.

Blink engine:
- A 32-bit counter increments every cycle.
- When counter == PERIOD-1, the counter wraps to 0 and phase toggles.
- If PERIOD==0, the counter holds at 0 and phase holds at 1.
- A write to PERIOD resets the counter to 0; phase is unchanged.

LED output:
- led_out is updated on each edge as follows.
  - enable=0: 0.
  - enable=1, blink=0: VALUE.
  - enable=1, blink=1: VALUE & {LED_COUNT{phase}}.

## Timing
Reset (rst_n low, asynchronous assert, synchronous release):
- awready=wready=arready=0 while rst_n is low; they go to 1 on the first edge after release.
- bvalid=rvalid=0.
- bresp=rresp=0.
- rdata=0.
- led_out=0.
- phase=0.
- counter=0.
- All registers are at their reset values.

Latencies:
- Write: 1 cycle from the later of the AW/W handshakes to bvalid.
- Read: 1 cycle from the AR handshake to rvalid.
- Register write to led_out: 1 cycle. A write committing at edge N+1 is reflected in led_out at edge N+2.

Throughput and backpressure:
- One outstanding write and one outstanding read at a time. With bready and rready held high, the sustained rate is one write every 2 cycles and one read every 2 cycles.
- Reads and writes proceed concurrently.
- A read issued in the same cycle as a write commit returns the pre-write value.

Reset mid-transaction:
- Pending AW/W holds, bvalid and rvalid are dropped immediately.
- No response is produced for the interrupted transaction.

## Test plan
- Reset/ID: release reset, read 0x10 → rdata=0x4C454401, rresp=0, rvalid exactly 1 cycle after the AR handshake; led_out=0.
- Split write: send W (data 0xA5, strb 0x1) 3 cycles before AW (0x04) → bvalid 1 cycle after the AW handshake, bresp=0; read 0x04 returns 0x000000A5.
- Strobes: write 0x04 with 0xFFFFFFFF, strb 0x2 after VALUE=0xA5 → VALUE reads 0x0000FFA5 masked to LED_COUNT bits (0xA5 for LED_COUNT=8).
- Blink: VALUE=0x0F, PERIOD=4, CTRL=3 → led_out alternates 0x00/0x0F every 4 cycles; set PERIOD=0 → led_out steady 0x0F.
- Errors/backpressure: read 0x20 → rdata=0, rresp=2; write 0x14 → bresp=2; hold bready low 5 cycles → bvalid stays high, awready stays 0.
- Async reset mid-write: assert rst_n low between the AW and W handshakes → bvalid never rises; led_out=0 immediately.

Source files
------------

// File: rtl/axil_led_ctrl.sv
// axil_led_ctrl
//   AXI4-Lite register slave driving an LED bank with a static or blinking
//   pattern. Register map (addr[7:2] decoded, aliases every 256 bytes):
//     0x00 CTRL   RW  [0] enable, [1] blink
//     0x04 VALUE  RW  [LED_COUNT-1:0] LED pattern
//     0x08 PERIOD RW  blink half-period in clk cycles
//     0x0C STATUS RO  [0] phase, [LED_COUNT+7:8] current led_out
//     0x10 ID     RO  ID_VALUE
//     0x14-0xFF   unmapped: SLVERR, writes dropped, reads return 0
//
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   s_axil_aw*        write address channel (awprot ignored)
//   s_axil_w*         write data channel
//   s_axil_b*         write response channel
//   s_axil_ar*        read address channel (arprot ignored)
//   s_axil_r*         read data channel
//   led_out           registered LED drive, active-high
//
// Handshake semantics: a beat transfers on a rising edge where valid and
// ready are both high. A source holds valid and its payload stable until that
// edge; ready may depend on internal state only, never on valid. AW and W are
// captured independently into holding registers; the write commits on the
// edge where the second of the two transfers (or both together), raising
// bvalid at that edge. bvalid/rvalid and their payloads hold until the
// edge where bready/rready is high.
module axil_led_ctrl #(
  parameter int          DATA_WIDTH = 32,
  parameter int          ADDR_WIDTH = 16,
  parameter int          STRB_WIDTH = DATA_WIDTH / 8,
  parameter int          LED_COUNT  = 8,
  parameter logic [31:0] ID_VALUE   = 32'h4C45_4401
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [ADDR_WIDTH-1:0] s_axil_awaddr,
  input  logic [2:0]            s_axil_awprot,
  input  logic                  s_axil_awvalid,
  output logic                  s_axil_awready,
  input  logic [DATA_WIDTH-1:0] s_axil_wdata,
  input  logic [STRB_WIDTH-1:0] s_axil_wstrb,
  input  logic                  s_axil_wvalid,
  output logic                  s_axil_wready,
  output logic [1:0]            s_axil_bresp,
  output logic                  s_axil_bvalid,
  input  logic                  s_axil_bready,
  input  logic [ADDR_WIDTH-1:0] s_axil_araddr,
  input  logic [2:0]            s_axil_arprot,
  input  logic                  s_axil_arvalid,
  output logic                  s_axil_arready,
  output logic [DATA_WIDTH-1:0] s_axil_rdata,
  output logic [1:0]            s_axil_rresp,
  output logic                  s_axil_rvalid,
  input  logic                  s_axil_rready,
  output logic [LED_COUNT-1:0]  led_out
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  localparam logic [5:0] REG_CTRL   = 6'd0;
  localparam logic [5:0] REG_VALUE  = 6'd1;
  localparam logic [5:0] REG_PERIOD = 6'd2;
  localparam logic [5:0] REG_STATUS = 6'd3;
  localparam logic [5:0] REG_ID     = 6'd4;

  // Byte-lane merge of a write into the current 32-bit register image.
  function automatic logic [31:0] strb_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (strb[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------- state
  logic                 ready_en;   // keeps all readies low until the first edge after reset
  logic                 aw_held;
  logic [5:0]           aw_idx_q;
  logic                 w_held;
  logic [31:0]          w_data_q;
  logic [3:0]           w_strb_q;
  logic                 bvalid_q;
  logic [1:0]           bresp_q;
  logic                 rvalid_q;
  logic [31:0]          rdata_q;
  logic [1:0]           rresp_q;

  logic                 ctrl_enable;
  logic                 ctrl_blink;
  logic [LED_COUNT-1:0] value_reg;
  logic [31:0]          period_reg;
  logic [31:0]          counter;
  logic                 phase;
  logic [LED_COUNT-1:0] led_q;

  // ---------------------------------------------------------------- handshakes
  assign s_axil_awready = ready_en && !aw_held && !bvalid_q;
  assign s_axil_wready  = ready_en && !w_held && !bvalid_q;
  assign s_axil_arready = ready_en && !rvalid_q;

  logic aw_hs, w_hs, ar_hs, wr_fire;
  assign aw_hs   = s_axil_awvalid && s_axil_awready;
  assign w_hs    = s_axil_wvalid && s_axil_wready;
  assign ar_hs   = s_axil_arvalid && s_axil_arready;
  assign wr_fire = (aw_held || aw_hs) && (w_held || w_hs);

  // Effective write beat: the held copy if present, else the live bus.
  logic [5:0]  wr_idx;
  logic [31:0] wr_data;
  logic [3:0]  wr_strb;
  logic        wr_mapped;
  assign wr_idx    = aw_held ? aw_idx_q : s_axil_awaddr[7:2];
  assign wr_data   = w_held ? w_data_q : s_axil_wdata;
  assign wr_strb   = w_held ? w_strb_q : s_axil_wstrb;
  assign wr_mapped = (wr_idx <= REG_ID);

  logic [31:0] ctrl_merged, value_merged, period_merged;
  assign ctrl_merged   = strb_merge({30'd0, ctrl_blink, ctrl_enable}, wr_data, wr_strb);
  assign value_merged  = strb_merge(32'(value_reg), wr_data, wr_strb);
  assign period_merged = strb_merge(period_reg, wr_data, wr_strb);

  logic period_wr;
  assign period_wr = wr_fire && (wr_idx == REG_PERIOD);

  // ---------------------------------------------------------------- write channel
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ready_en <= 1'b0;
      aw_held  <= 1'b0;
      aw_idx_q <= '0;
      w_held   <= 1'b0;
      w_data_q <= '0;
      w_strb_q <= '0;
      bvalid_q <= 1'b0;
      bresp_q  <= RESP_OKAY;
    end else begin
      ready_en <= 1'b1;
      if (wr_fire) begin
        aw_held  <= 1'b0;
        w_held   <= 1'b0;
        bvalid_q <= 1'b1;
        bresp_q  <= wr_mapped ? RESP_OKAY : RESP_SLVERR;
      end else begin
        if (aw_hs) begin
          aw_held  <= 1'b1;
          aw_idx_q <= s_axil_awaddr[7:2];
        end
        if (w_hs) begin
          w_held   <= 1'b1;
          w_data_q <= s_axil_wdata;
          w_strb_q <= s_axil_wstrb;
        end
        if (bvalid_q && s_axil_bready) bvalid_q <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ctrl_enable <= 1'b0;
      ctrl_blink  <= 1'b0;
      value_reg   <= '0;
      period_reg  <= '0;
    end else if (wr_fire) begin
      case (wr_idx)
        REG_CTRL: begin
          ctrl_enable <= ctrl_merged[0];
          ctrl_blink  <= ctrl_merged[1];
        end
        REG_VALUE:  value_reg  <= value_merged[LED_COUNT-1:0];
        REG_PERIOD: period_reg <= period_merged;
        default: ;  // RO and unmapped offsets: nothing to update
      endcase
    end
  end

  // ---------------------------------------------------------------- blink engine
  // PERIOD==0 parks the engine with phase=1 so a blinking pattern shows solid.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      counter <= '0;
      phase   <= 1'b0;
    end else if (period_wr) begin
      counter <= '0;
    end else if (period_reg == 32'd0) begin
      counter <= '0;
      phase   <= 1'b1;
    end else if (counter == period_reg - 32'd1) begin
      counter <= '0;
      phase   <= ~phase;
    end else begin
      counter <= counter + 32'd1;
    end
  end

  // ---------------------------------------------------------------- LED output
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      led_q <= '0;
    end else if (!ctrl_enable) begin
      led_q <= '0;
    end else if (ctrl_blink) begin
      led_q <= value_reg & {LED_COUNT{phase}};
    end else begin
      led_q <= value_reg;
    end
  end

  assign led_out = led_q;

  // ---------------------------------------------------------------- read channel
  logic [31:0] rd_data;
  logic [1:0]  rd_resp;

  always_comb begin
    rd_data = '0;
    rd_resp = RESP_OKAY;
    case (s_axil_araddr[7:2])
      REG_CTRL:   rd_data[1:0] = {ctrl_blink, ctrl_enable};
      REG_VALUE:  rd_data[LED_COUNT-1:0] = value_reg;
      REG_PERIOD: rd_data = period_reg;
      REG_STATUS: begin
        rd_data[0]             = phase;
        rd_data[LED_COUNT+7:8] = led_q;
      end
      REG_ID:     rd_data = ID_VALUE;
      default:    rd_resp = RESP_SLVERR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
      rresp_q  <= RESP_OKAY;
    end else if (ar_hs) begin
      rvalid_q <= 1'b1;
      rdata_q  <= rd_data;
      rresp_q  <= rd_resp;
    end else if (rvalid_q && s_axil_rready) begin
      rvalid_q <= 1'b0;
    end
  end

  assign s_axil_bvalid = bvalid_q;
  assign s_axil_bresp  = bresp_q;
  assign s_axil_rvalid = rvalid_q;
  assign s_axil_rdata  = rdata_q;
  assign s_axil_rresp  = rresp_q;

  // Protection bits, ignored address bits and merge bits beyond each
  // register's width are intentionally dropped.
  logic unused_ok;
  assign unused_ok = ^{s_axil_awprot, s_axil_arprot,
                       s_axil_awaddr[ADDR_WIDTH-1:8], s_axil_awaddr[1:0],
                       s_axil_araddr[ADDR_WIDTH-1:8], s_axil_araddr[1:0],
                       ctrl_merged, value_merged};

endmodule

// File: tb/tb_axil_led_ctrl.sv
module tb_axil_led_ctrl;

  localparam int          LED_COUNT = 8;
  localparam logic [31:0] ID_VALUE  = 32'h4C45_4401;

  // ---------------------------------------------------------------- clock / reset
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] awaddr = '0;
  logic [2:0]  awprot = '0;
  logic        awvalid = 1'b0;
  logic        awready;
  logic [31:0] wdata = '0;
  logic [3:0]  wstrb = '0;
  logic        wvalid = 1'b0;
  logic        wready;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready = 1'b1;
  logic [15:0] araddr = '0;
  logic [2:0]  arprot = '0;
  logic        arvalid = 1'b0;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready = 1'b1;
  logic [LED_COUNT-1:0] led_out;

  axil_led_ctrl #(.LED_COUNT(LED_COUNT), .ID_VALUE(ID_VALUE)) dut (
    .clk(clk), .rst_n(rst_n),
    .s_axil_awaddr(awaddr), .s_axil_awprot(awprot), .s_axil_awvalid(awvalid), .s_axil_awready(awready),
    .s_axil_wdata(wdata), .s_axil_wstrb(wstrb), .s_axil_wvalid(wvalid), .s_axil_wready(wready),
    .s_axil_bresp(bresp), .s_axil_bvalid(bvalid), .s_axil_bready(bready),
    .s_axil_araddr(araddr), .s_axil_arprot(arprot), .s_axil_arvalid(arvalid), .s_axil_arready(arready),
    .s_axil_rdata(rdata), .s_axil_rresp(rresp), .s_axil_rvalid(rvalid), .s_axil_rready(rready),
    .led_out(led_out)
  );

  // ---------------------------------------------------------------- scoreboard
  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------- drivers
  // All drivers start and end on a falling edge.
  task automatic do_write(input logic [15:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input int b_stall,
                          output logic [1:0] resp);
    bit aw_d, w_d, a_hs, d_hs;
    int n;
    awaddr = addr; wdata = data; wstrb = strb;
    awvalid = 1'b1; wvalid = 1'b1; bready = (b_stall == 0);
    aw_d = 1'b0; w_d = 1'b0; n = 0;
    while (!(aw_d && w_d) && n < 20) begin
      a_hs = awvalid && awready;
      d_hs = wvalid && wready;
      @(negedge clk); n++;
      if (a_hs) begin aw_d = 1'b1; awvalid = 1'b0; end
      if (d_hs) begin w_d = 1'b1; wvalid = 1'b0; end
    end
    awvalid = 1'b0; wvalid = 1'b0;
    chk("wr_hs_timeout", 32'(n < 20), 32'd1);
    chk("wr_bvalid_lat", 32'(bvalid), 32'd1);
    resp = bresp;
    for (int k = 0; k < b_stall; k++) begin
      chk("b_stall_bvalid", 32'(bvalid), 32'd1);
      chk("b_stall_awready", 32'(awready), 32'd0);
      chk("b_stall_bresp", 32'(bresp), 32'(resp));
      @(negedge clk);
    end
    bready = 1'b1;
    @(negedge clk);
    chk("wr_bvalid_clear", 32'(bvalid), 32'd0);
  endtask

  task automatic do_read(input logic [15:0] addr, output logic [31:0] data,
                         output logic [1:0] resp);
    int n;
    araddr = addr; arvalid = 1'b1; rready = 1'b1; n = 0;
    while (!arready && n < 20) begin @(negedge clk); n++; end
    chk("rd_hs_timeout", 32'(n < 20), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    chk("rd_rvalid_lat", 32'(rvalid), 32'd1);
    data = rdata; resp = rresp;
    @(negedge clk);
    chk("rd_rvalid_clear", 32'(rvalid), 32'd0);
  endtask

  // ---------------------------------------------------------------- reference model
  // Register contents as the software view sees them; readback is computed
  // from byte-enable masking and each register's implemented width.
  logic [31:0] mdl_reg[3];
  localparam logic [31:0] IMPL_MASK[3] = '{32'h3, (32'h1 << LED_COUNT) - 32'h1, 32'hFFFF_FFFF};

  function automatic logic [31:0] mdl_write(input logic [31:0] old_v, input logic [31:0] d,
                                            input logic [3:0] s, input int idx);
    logic [31:0] m;
    m = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
    return ((old_v & ~m) | (d & m)) & IMPL_MASK[idx];
  endfunction

  // ---------------------------------------------------------------- vector table
  typedef struct {
    bit          is_wr;
    logic [15:0] addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp_data;
    logic [1:0]  exp_resp;
  } vec_t;
  vec_t vecs[$];

  function automatic void add(bit w, logic [15:0] a, logic [31:0] d, logic [3:0] s,
                              logic [31:0] ed, logic [1:0] er);
    vec_t v;
    v.is_wr = w; v.addr = a; v.data = d; v.strb = s; v.exp_data = ed; v.exp_resp = er;
    vecs.push_back(v);
  endfunction

  logic [1:0]  resp;
  logic [31:0] rd;
  logic [7:0]  samples[40];

  initial begin
    // table runs right after the split write, so VALUE=0xA5 and PERIOD=0
    add(1, 16'h0004, 32'hFFFF_FFFF, 4'h2, 32'h0,         2'b00); // strobe outside LED width
    add(0, 16'h0004, 32'h0,         4'h0, 32'h0000_00A5, 2'b00);
    add(0, 16'h0020, 32'h0,         4'h0, 32'h0,         2'b10); // unmapped read
    add(1, 16'h0014, 32'h1234,      4'hF, 32'h0,         2'b10); // unmapped write
    add(0, 16'h0014, 32'h0,         4'h0, 32'h0,         2'b10);
    add(1, 16'h0010, 32'h0,         4'hF, 32'h0,         2'b00); // RO write ignored
    add(0, 16'h0010, 32'h0,         4'h0, ID_VALUE,      2'b00);
    add(0, 16'h0113, 32'h0,         4'h0, ID_VALUE,      2'b00); // alias + low bits
    add(1, 16'h0008, 32'h0000_0123, 4'h1, 32'h0,         2'b00);
    add(0, 16'h0008, 32'h0,         4'h0, 32'h0000_0023, 2'b00);
    add(1, 16'h0A0B, 32'h1234_5678, 4'hC, 32'h0,         2'b00); // aliased PERIOD, upper lanes
    add(0, 16'h0008, 32'h0,         4'h0, 32'h1234_0023, 2'b00);
    add(1, 16'h0000, 32'hFFFF_FFFF, 4'h1, 32'h0,         2'b00);
    add(0, 16'h0000, 32'h0,         4'h0, 32'h0000_0003, 2'b00);
    add(1, 16'h0000, 32'h0,         4'hF, 32'h0,         2'b00);
    add(0, 16'h0000, 32'h0,         4'h0, 32'h0,         2'b00);
    add(1, 16'h0008, 32'h0,         4'hF, 32'h0,         2'b00);
    add(0, 16'h000C, 32'h0,         4'h0, 32'h0000_0001, 2'b00); // phase=1, led_out=0
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  // ---------------------------------------------------------------- test
  initial begin
    int runs, run_len, first_run;
    int ok;

    // ---- reset state
    #3;
    chk("rst_awready", 32'(awready), 32'd0);
    chk("rst_wready",  32'(wready),  32'd0);
    chk("rst_arready", 32'(arready), 32'd0);
    chk("rst_bvalid",  32'(bvalid),  32'd0);
    chk("rst_rvalid",  32'(rvalid),  32'd0);
    chk("rst_rdata",   rdata,        32'd0);
    chk("rst_led",     32'(led_out), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rel_arready", 32'(arready), 32'd1);
    chk("rel_awready", 32'(awready), 32'd1);

    // ---- ID read
    do_read(16'h0010, rd, resp);
    chk("id_rdata", rd, ID_VALUE);
    chk("id_rresp", 32'(resp), 32'd0);
    chk("id_led", 32'(led_out), 32'd0);

    // ---- split write: W three cycles ahead of AW
    chk("split_wready", 32'(wready), 32'd1);
    wvalid = 1'b1; wdata = 32'hA5; wstrb = 4'h1; awvalid = 1'b0; bready = 1'b1;
    @(negedge clk);
    wvalid = 1'b0;
    chk("split_w_held", 32'(wready), 32'd0);
    @(negedge clk); @(negedge clk);
    chk("split_no_b", 32'(bvalid), 32'd0);
    awvalid = 1'b1; awaddr = 16'h0004;
    @(negedge clk);
    awvalid = 1'b0;
    chk("split_bvalid", 32'(bvalid), 32'd1);
    chk("split_bresp", 32'(bresp), 32'd0);
    @(negedge clk);
    chk("split_b_clear", 32'(bvalid), 32'd0);
    do_read(16'h0004, rd, resp);
    chk("split_value", rd, 32'h0000_00A5);

    // ---- table
    foreach (vecs[i]) begin
      if (vecs[i].is_wr) begin
        do_write(vecs[i].addr, vecs[i].data, vecs[i].strb, 0, resp);
        chk($sformatf("tbl%0d_bresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end else begin
        do_read(vecs[i].addr, rd, resp);
        chk($sformatf("tbl%0d_rdata", i), rd, vecs[i].exp_data);
        chk($sformatf("tbl%0d_rresp", i), 32'(resp), 32'(vecs[i].exp_resp));
      end
    end

    // ---- blink: half-period 4 means runs of exactly 4 samples, alternating 0x00/0x0F
    do_write(16'h0004, 32'h0F, 4'hF, 0, resp);
    do_write(16'h0008, 32'd4,  4'hF, 0, resp);
    do_write(16'h0000, 32'd3,  4'hF, 0, resp);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 40; i++) begin
      samples[i] = led_out;
      @(negedge clk);
    end
    ok = 1;
    for (int i = 0; i < 40; i++) if (samples[i] != 8'h00 && samples[i] != 8'h0F) ok = 0;
    chk("blink_values", 32'(ok), 32'd1);
    runs = 0; run_len = 1; first_run = 1;
    for (int i = 1; i < 40; i++) begin
      if (samples[i] != samples[i-1]) begin
        if (!first_run) chk($sformatf("blink_run%0d", runs), 32'(run_len), 32'd4);
        first_run = 0; runs++; run_len = 1;
      end else begin
        run_len++;
      end
    end
    chk("blink_toggles", 32'(runs >= 8), 32'd1);

    do_write(16'h0008, 32'd0, 4'hF, 0, resp);
    @(negedge clk); @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      chk("steady_led", 32'(led_out), 32'h0F);
      @(negedge clk);
    end

    // ---- randomized register traffic against the model
    do_write(16'h0000, 32'd0, 4'hF, 0, resp);
    mdl_reg[0] = 32'd0; mdl_reg[1] = 32'h0F; mdl_reg[2] = 32'd0;
    for (int it = 0; it < 80; it++) begin
      int r, idx;
      logic [15:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      r = $urandom_range(0, 5);
      idx = (r <= 2) ? r : (r == 3) ? 4 : $urandom_range(5, 63);
      a = 16'(($urandom_range(0, 255) << 8) | (idx << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        s = 4'($urandom_range(0, 15));
        do_write(a, d, s, 0, resp);
        chk("rnd_bresp", 32'(resp), (idx <= 4) ? 32'd0 : 32'd2);
        if (idx <= 2) mdl_reg[idx] = mdl_write(mdl_reg[idx], d, s, idx);
      end else begin
        if (idx <= 2)       exp_q.push_back(mdl_reg[idx]);
        else if (idx == 4)  exp_q.push_back(ID_VALUE);
        else                exp_q.push_back(32'd0);
        do_read(a, rd, resp);
        chk("rnd_rdata", rd, exp_q.pop_front());
        chk("rnd_rresp", 32'(resp), (idx <= 4) ? 32'd0 : 32'd2);
      end
    end

    // ---- backpressure on an erroring write
    do_write(16'h0014, 32'hDEAD, 4'hF, 5, resp);
    chk("bp_bresp", 32'(resp), 32'd2);

    // ---- asynchronous reset between AW and W
    do_write(16'h0000, 32'd1, 4'hF, 0, resp);
    do_write(16'h0004, 32'hFF, 4'hF, 0, resp);
    @(negedge clk); @(negedge clk);
    chk("pre_rst_led", 32'(led_out), 32'hFF);
    awaddr = 16'h0004; awvalid = 1'b1; wvalid = 1'b0;
    begin
      int n;
      n = 0;
      while (!awready && n < 20) begin @(negedge clk); n++; end
      chk("mid_aw_timeout", 32'(n < 20), 32'd1);
    end
    @(negedge clk);
    awvalid = 1'b0;
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_led", 32'(led_out), 32'd0);
    chk("mid_rst_awready", 32'(awready), 32'd0);
    chk("mid_rst_bvalid", 32'(bvalid), 32'd0);
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    wvalid = 1'b1; wdata = 32'h55; wstrb = 4'hF;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 2) wvalid = 1'b0;
      chk("mid_no_bvalid", 32'(bvalid), 32'd0);
    end
    wvalid = 1'b0;
    do_read(16'h0004, rd, resp);
    chk("mid_value_reset", rd, 32'd0);
    chk("mid_led_after", 32'(led_out), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
